// File: rtl/dragon_pkg.sv
// Shared command codes, segment layout and scan FSM encoding for the dragon body blocks.
package dragon_pkg;
  localparam int NUM_SEGS = 7;
  localparam int SEG_W    = 10;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    ST_MOVE = 2'b00,
    ST_HEAL = 2'b01,
    ST_HIT  = 2'b10,
    ST_IDLE = 2'b11
  } body_cmd_e;

  typedef enum logic [1:0] {
    FSM_WAIT   = 2'b00,
    FSM_SCAN   = 2'b01,
    FSM_REPORT = 2'b10
  } scan_fsm_e;

  // ORIENT[9:8], POS_X[7:4], POS_Y[3:0]
  typedef struct packed {
    logic [1:0] orient;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
  } seg_t;
endpackage

// File: rtl/vsync_rise_detect.sv
// Frame tick: registered rising-edge pulse of raw vsync, one clk wide.
module vsync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic rise
);
  logic prev_vsync;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vsync <= 1'b0;
      rise       <= 1'b0;
    end else begin
      prev_vsync <= vsync;
      rise       <= vsync & ~prev_vsync;
    end
  end
endmodule

// File: rtl/dragon_hit_arbiter.sv
// Per-frame sword-vs-segment scan; emits one-cycle HIT/HEAL commands to the dragon body
// with post-hit invulnerability and hit-over-heal priority.
module dragon_hit_arbiter
  import dragon_pkg::*;
#(
  parameter int INVULN_FRAMES = 30,
  parameter int CD_W          = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic [NUM_SEGS*SEG_W-1:0] dragon_segs,
  input  logic [NUM_SEGS-1:0]       display_en,
  input  logic                      sword_active,
  input  logic [7:0]                sword_pos,
  input  logic                      heal_req,
  output logic [1:0]                states,
  output logic [IDX_W-1:0]          hit_index,
  output logic                      scan_busy
);
  localparam int PAD = (2**IDX_W) - NUM_SEGS;

  logic                        rise;
  scan_fsm_e                   state, state_nxt;
  logic [IDX_W-1:0]            idx, match_idx;
  logic                        found, sw_act, heal_pend;
  logic [7:0]                  sw_pos;
  logic [CD_W-1:0]             cooldown;
  logic [2**IDX_W-1:0][SEG_W-1:0] segs_pad;
  logic [2**IDX_W-1:0]         en_pad;
  seg_t                        cur_seg;
  logic                        cur_match, do_hit, do_heal;
  logic                        unused_orient;

  vsync_rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .rise  (rise)
  );

  // Pad to a power of two so the 3-bit index never selects outside the vectors.
  assign segs_pad = {{(PAD*SEG_W){1'b0}}, dragon_segs};
  assign en_pad   = {{PAD{1'b0}}, display_en};
  assign cur_seg  = seg_t'(segs_pad[idx]);
  assign unused_orient = ^cur_seg.orient;

  assign cur_match = en_pad[idx] & sw_act & ({cur_seg.pos_x, cur_seg.pos_y} == sw_pos);
  assign do_hit    = (state == FSM_REPORT) & found & (cooldown == '0);
  assign do_heal   = (state == FSM_REPORT) & ~do_hit & heal_pend;
  assign scan_busy = (state == FSM_SCAN) | (state == FSM_REPORT);

  always_comb begin
    state_nxt = state;
    case (state)
      FSM_WAIT:   if (rise) state_nxt = FSM_SCAN;
      FSM_SCAN:   if (idx == IDX_W'(NUM_SEGS-1)) state_nxt = FSM_REPORT;
      FSM_REPORT: state_nxt = FSM_WAIT;
      default:    state_nxt = FSM_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FSM_WAIT;
      states    <= ST_IDLE;
      hit_index <= '0;
      idx       <= '0;
      match_idx <= '0;
      found     <= 1'b0;
      sw_act    <= 1'b0;
      sw_pos    <= '0;
      cooldown  <= '0;
      heal_pend <= 1'b0;
    end else begin
      state <= state_nxt;

      if (do_hit)       states <= ST_HIT;
      else if (do_heal) states <= ST_HEAL;
      else              states <= ST_IDLE;

      if (state == FSM_WAIT && rise) begin
        sw_act <= sword_active;
        sw_pos <= sword_pos;
        idx    <= '0;
        found  <= 1'b0;
        if (cooldown != '0) cooldown <= cooldown - 1'b1;
      end

      if (state == FSM_SCAN) begin
        if (cur_match && !found) begin
          found     <= 1'b1;
          match_idx <= idx;
        end
        if (idx != IDX_W'(NUM_SEGS-1)) idx <= idx + 1'b1;
      end

      if (do_hit) begin
        hit_index <= match_idx;
        cooldown  <= CD_W'(INVULN_FRAMES);
      end

      // A request arriving in the REPORT clk survives the consume and waits a frame.
      heal_pend <= heal_req | (heal_pend & ~do_heal);
    end
  end
endmodule

// File: tb/tb_dragon_hit_arbiter.sv
// Directed bench for dragon_hit_arbiter: frame-level reference model plus literal spot checks.
module tb_dragon_hit_arbiter;
  logic        clk = 1'b0;
  logic        reset, vsync, sword_active, heal_req;
  logic [69:0] dragon_segs;
  logic [6:0]  display_en;
  logic [7:0]  sword_pos;
  logic [1:0]  states;
  logic [2:0]  hit_index;
  logic        scan_busy;

  int checks = 0;
  int fails  = 0;
  int n_hit  = 0;
  int n_heal = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  dragon_hit_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .dragon_segs  (dragon_segs),
    .display_en   (display_en),
    .sword_active (sword_active),
    .sword_pos    (sword_pos),
    .heal_req     (heal_req),
    .states       (states),
    .hit_index    (hit_index),
    .scan_busy    (scan_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a rise seen on one edge starts a frame on the next edge if idle;
  // the verdict lands 8 edges later. Inputs are held steady over a frame.
  logic       m_prev, m_rise;
  int         m_left, m_cd, m_idx;
  bit         m_pend, m_found;
  logic [1:0] exp_states;
  logic [2:0] exp_hit;
  logic       exp_busy;

  always @(posedge clk) begin
    if (reset) begin
      m_prev = 0; m_rise = 0; m_left = 0; m_cd = 0; m_pend = 0; m_found = 0; m_idx = 0;
      exp_states = 2'b11; exp_hit = 3'd0; exp_busy = 1'b0;
    end else begin
      exp_states = 2'b11;
      if (m_left == 0 && m_rise) begin
        m_left = 8;
        if (m_cd > 0) m_cd--;
        m_found = 0;
        for (int i = 6; i >= 0; i--)
          if (display_en[i] && sword_active && dragon_segs[10*i +: 8] == sword_pos) begin
            m_found = 1;
            m_idx   = i;
          end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_found && m_cd == 0) begin
            exp_states = 2'b10; exp_hit = 3'(m_idx); m_cd = 30;
          end else if (m_pend) begin
            exp_states = 2'b01; m_pend = 0;
          end
        end
      end
      if (heal_req) m_pend = 1;
      exp_busy = (m_left != 0);
      m_rise   = vsync && !m_prev;
      m_prev   = vsync;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("states", int'(states), int'(exp_states));
      check("hit_index", int'(hit_index), int'(exp_hit));
      check("scan_busy", int'(scan_busy), int'(exp_busy));
      if (states == 2'b10) n_hit++;
      if (states == 2'b01) n_heal++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b1; tick(2);
    vsync = 1'b0; tick(12);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(3);
    reset = 1'b0; tick(1);
  endtask

  // All segments parked at X=A, Y=i so nothing matches sword 8'h53.
  task automatic park_segs();
    for (int i = 0; i < 7; i++) dragon_segs[10*i +: 10] = {2'b00, 4'hA, 4'(i)};
  endtask

  int h0, e0;

  initial begin
    reset = 1'b1; vsync = 1'b0; sword_active = 1'b0; heal_req = 1'b0;
    dragon_segs = '0; display_en = '0; sword_pos = '0;
    tick(1);
    chk_en = 1;
    tick(2);
    reset = 1'b0; tick(1);

    // 1: reset mid-scan aborts scan and drops the pending heal
    park_segs();
    dragon_segs[9:0] = {2'b10, 4'h5, 4'h3};
    display_en = 7'b1111111; sword_active = 1'b1; sword_pos = 8'h53;
    heal_req = 1'b1; tick(1); heal_req = 1'b0;
    vsync = 1'b1; tick(2); vsync = 1'b0; tick(3);
    reset = 1'b1; tick(3);
    check("rst_states", int'(states), 3);
    check("rst_busy", int'(scan_busy), 0);
    check("rst_hit_index", int'(hit_index), 0);
    reset = 1'b0; tick(2);
    h0 = n_hit; e0 = n_heal;
    frame();
    check("t1_hits", n_hit - h0, 1);
    check("t1_hit_index", int'(hit_index), 0);
    frame();
    check("t1_heal_dropped", n_heal - e0, 0);

    // 2: seg2 hit, 9-clk latency, one-clk pulse
    do_reset();
    park_segs();
    dragon_segs[29:20] = {2'b01, 4'h5, 4'h3};
    display_en = 7'b0000111;
    vsync = 1'b1; tick(2); vsync = 1'b0; tick(7);
    check("t2_before", int'(states), 3);
    tick(1);
    check("t2_pulse", int'(states), 2);
    check("t2_hit_index", int'(hit_index), 2);
    tick(1);
    check("t2_after", int'(states), 3);
    tick(4);

    // 3: invulnerability for frames 2..30, hit again on frame 31
    h0 = n_hit;
    repeat (29) frame();
    check("t3_suppressed", n_hit - h0, 0);
    frame();
    check("t3_frame31", n_hit - h0, 1);

    // 4: seg1 and seg4 both match -> lowest index wins
    do_reset();
    park_segs();
    dragon_segs[19:10] = {2'b11, 4'h5, 4'h3};
    dragon_segs[49:40] = {2'b00, 4'h5, 4'h3};
    display_en = 7'b1111111;
    h0 = n_hit;
    frame();
    check("t4_hits", n_hit - h0, 1);
    check("t4_hit_index", int'(hit_index), 1);

    // 5: heal with hit in the same frame -> HIT now, HEAL next frame, then nothing
    do_reset();
    park_segs();
    dragon_segs[29:20] = {2'b01, 4'h5, 4'h3};
    display_en = 7'b0000111;
    h0 = n_hit; e0 = n_heal;
    heal_req = 1'b1; tick(1); heal_req = 1'b0;
    frame();
    check("t5_hit", n_hit - h0, 1);
    check("t5_no_heal_yet", n_heal - e0, 0);
    frame();
    check("t5_heal", n_heal - e0, 1);
    frame();
    check("t5_heal_once", n_heal - e0, 1);
    check("t5_hit_once", n_hit - h0, 1);

    // 6: hidden segment / sword away -> no hit, cooldown untouched
    do_reset();
    park_segs();
    dragon_segs[59:50] = {2'b00, 4'h5, 4'h3};
    display_en = 7'b1011111;
    h0 = n_hit;
    frame();
    check("t6_hidden", n_hit - h0, 0);
    display_en = 7'b1111111; sword_active = 1'b0;
    frame();
    check("t6_sword_off", n_hit - h0, 0);
    sword_active = 1'b1;
    // second rise lands mid-scan and must not start another frame
    vsync = 1'b1; tick(2); vsync = 1'b0; tick(2);
    vsync = 1'b1; tick(2); vsync = 1'b0; tick(14);
    check("t6_hit_after", n_hit - h0, 1);
    check("t6_hit_index", int'(hit_index), 5);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
